// File: rtl/router_pkg.sv
// Shared router types and constants: byte width, FIFO depth, header field layout.
package router_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int PKT_CNT_W  = 7;

  // Header byte layout: len occupies [7:2], destination addr occupies [1:0].
  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  // Bytes still to drain after the header: payload plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] pkt_len(input hdr_t h);
    return PKT_CNT_W'(h.len) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake and status bundle for one router output FIFO.
interface router_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
);
  logic                  write_enb;
  logic                  read_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  busy;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, busy
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, busy
  );
endinterface

// File: rtl/router_fifo.sv
// Output-port FIFO of the 1x3 router: tagged byte storage plus a packet drain counter.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int DEPTH      = router_pkg::FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          reset,
  input logic          soft_reset,
  router_fifo_if.slave bus
);

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   rd_entry;
  logic [PKT_CNT_W-1:0]  pkt_count;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  lfd_d;
  logic                  full;
  logic                  empty;
  logic                  do_write;
  logic                  do_read;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign do_write = bus.write_enb && !full;
  assign do_read  = bus.read_enb && !empty;
  assign rd_entry = mem[rd_ptr[ADDR_WIDTH-1:0]];

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.busy     = (pkt_count != '0);
  assign bus.data_out = data_out_q;

  // Storage is not reset; the tag is the header flag delayed to line up with its byte.
  always_ff @(posedge clk) begin
    if (!soft_reset && do_write)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {lfd_d, bus.data_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      lfd_d      <= 1'b0;
      data_out_q <= '0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      lfd_d      <= 1'b0;
      data_out_q <= '0;
    end else begin
      lfd_d <= bus.lfd_state;

      if (do_write)
        wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);

      if (do_read) begin
        rd_ptr     <= rd_ptr + (ADDR_WIDTH+1)'(1);
        data_out_q <= rd_entry[DATA_WIDTH-1:0];
        if (rd_entry[DATA_WIDTH])
          pkt_count <= pkt_len(hdr_t'(rd_entry[DATA_WIDTH-1:0]));
        else if (pkt_count != '0)
          pkt_count <= pkt_count - PKT_CNT_W'(1);
      end else if (pkt_count == '0) begin
        data_out_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue-based reference model plus directed literal checks.
module tb_router_fifo;
  import router_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic soft_reset = 1'b0;

  router_fifo_if bus ();

  router_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of {tag, byte} entries and a drain count.
  logic [8:0] mq [$];
  logic [6:0] mcnt  = '0;
  logic       mlfd  = 1'b0;
  logic [7:0] mdout = '0;
  logic [8:0] m_e;
  bit         m_rd, m_wr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete(); mcnt = '0; mlfd = 1'b0; mdout = '0;
    end else if (soft_reset) begin
      mq.delete(); mcnt = '0; mlfd = 1'b0; mdout = '0;
    end else begin
      m_rd = bus.read_enb  && (mq.size() != 0);
      m_wr = bus.write_enb && (mq.size() != 16);
      if (m_rd) begin
        m_e   = mq.pop_front();
        mdout = m_e[7:0];
        if (m_e[8])          mcnt = 7'(m_e[7:2]) + 7'd1;
        else if (mcnt != 0)  mcnt = mcnt - 7'd1;
      end else if (mcnt == 0) begin
        mdout = '0;
      end
      if (m_wr) mq.push_back({mlfd, bus.data_in});
      mlfd = bus.lfd_state;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc data_out", 32'(bus.data_out), 32'(mdout));
      chk("cyc full",     32'(bus.full),     32'(mq.size() == 16));
      chk("cyc empty",    32'(bus.empty),    32'(mq.size() == 0));
      chk("cyc busy",     32'(bus.busy),     32'(mcnt != 0));
    end
  end

  task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] din);
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pkt_bytes [5];
  logic [7:0] pkt_busy  [5];
  int rd_idx;

  initial begin
    bus.write_enb = 1'b0; bus.read_enb = 1'b0; bus.lfd_state = 1'b0; bus.data_in = '0;
    pkt_bytes[0] = 8'h0D; pkt_bytes[1] = 8'h11; pkt_bytes[2] = 8'h22;
    pkt_bytes[3] = 8'h33; pkt_bytes[4] = 8'h1F;
    pkt_busy[0] = 1; pkt_busy[1] = 1; pkt_busy[2] = 1; pkt_busy[3] = 1; pkt_busy[4] = 0;

    #12;
    chk("reset empty", 32'(bus.empty), 1);
    chk("reset full",  32'(bus.full), 0);
    chk("reset busy",  32'(bus.busy), 0);
    chk("reset data_out", 32'(bus.data_out), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Packet: header flag one cycle ahead of the header byte.
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h0D);
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(1, 0, 0, 8'h1F);
    chk("pkt occupancy", 32'(mq.size()), 5);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h00);
      chk("pkt data_out", 32'(bus.data_out), 32'(pkt_bytes[i]));
      chk("pkt busy", 32'(bus.busy), 32'(pkt_busy[i]));
    end
    chk("pkt model count", 32'(mcnt), 0);
    step(0, 0, 0, 8'h00);
    chk("pkt idle data_out", 32'(bus.data_out), 0);
    chk("pkt empty", 32'(bus.empty), 1);

    // Fill to full, drop the 17th, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h40 + 8'(i));
      chk("fill full", 32'(bus.full), 32'(i == 15));
    end
    step(1, 0, 0, 8'hEE);
    chk("overflow full", 32'(bus.full), 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      chk("drain data", 32'(bus.data_out), 32'(8'h40 + 8'(i)));
    end
    chk("drain empty", 32'(bus.empty), 1);
    step(0, 1, 0, 8'h00);
    chk("underflow data_out", 32'(bus.data_out), 0);

    // Full with both requests: read wins, write dropped.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h80 + 8'(i));
    step(1, 1, 0, 8'hFF);
    chk("full rw data_out", 32'(bus.data_out), 32'h80);
    chk("full rw full", 32'(bus.full), 0);
    chk("full rw occupancy", 32'(mq.size()), 15);
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      chk("full rw drain", 32'(bus.data_out), 32'(8'h80 + 8'(i)));
    end
    step(0, 0, 0, 8'h00);

    // Empty with both requests: write wins, read ignored.
    step(1, 1, 0, 8'h55);
    chk("empty rw data_out", 32'(bus.data_out), 0);
    chk("empty rw empty", 32'(bus.empty), 0);
    step(0, 1, 0, 8'h00);
    chk("empty rw read", 32'(bus.data_out), 32'h55);

    // Interleaved traffic across the pointer wrap.
    rd_idx = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, (i % 2) == 1, 0, 8'hA0 + 8'(i));
      if ((i % 2) == 1) begin
        chk("wrap read", 32'(bus.data_out), 32'(8'hA0 + 8'(rd_idx)));
        rd_idx++;
      end
    end
    while (rd_idx < 20) begin
      step(0, 1, 0, 8'h00);
      chk("wrap drain", 32'(bus.data_out), 32'(8'hA0 + 8'(rd_idx)));
      rd_idx++;
    end
    chk("wrap empty", 32'(bus.empty), 1);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'hC0 + 8'(i));
    chk("wrap full", 32'(bus.full), 1);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    chk("wrap empty again", 32'(bus.empty), 1);
    step(0, 0, 0, 8'h00);

    // Soft reset mid-packet: count 3 with 5 entries left.
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h0D);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h60 + 8'(i));
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("pre soft occupancy", 32'(mq.size()), 5);
    chk("pre soft count", 32'(mcnt), 3);
    chk("pre soft busy", 32'(bus.busy), 1);
    soft_reset = 1'b1;
    step(1, 1, 0, 8'h77);
    soft_reset = 1'b0;
    chk("soft empty", 32'(bus.empty), 1);
    chk("soft busy", 32'(bus.busy), 0);
    chk("soft data_out", 32'(bus.data_out), 0);

    // Async reset pulse in the middle of a write cycle.
    step(1, 0, 0, 8'h91);
    step(1, 0, 0, 8'h92);
    bus.write_enb = 1'b1; bus.data_in = 8'h93;
    #2 reset = 1'b0;
    #1;
    chk("async empty", 32'(bus.empty), 1);
    chk("async full",  32'(bus.full), 0);
    chk("async busy",  32'(bus.busy), 0);
    bus.write_enb = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 8'h3C);
    step(0, 1, 0, 8'h00);
    chk("post reset read", 32'(bus.data_out), 32'h3C);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
